// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - decode-stage stall/flush sequencer with saturating event counters
module hazard_unit #(
    parameter int AWIDTH       = 5,
    parameter int CWIDTH       = 16,
    parameter int LU_STALL     = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              hu_clk,
    input  logic              hu_rst,
    input  logic              hu_i_ce,
    input  logic [AWIDTH-1:0] hu_i_addr_rs1,
    input  logic [AWIDTH-1:0] hu_i_addr_rs2,
    input  logic              hu_i_ex_ce,
    input  logic              hu_i_ex_load,
    input  logic [AWIDTH-1:0] hu_i_ex_addr_rd,
    input  logic              hu_i_branch_taken,
    input  logic              hu_i_mc_busy,
    output logic              hu_o_stall,
    output logic              hu_o_flush,
    output logic [1:0]        hu_o_state,
    output logic [CWIDTH-1:0] hu_o_stall_cnt,
    output logic [CWIDTH-1:0] hu_o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MC_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_REM = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] LU_REM    = 4'(LU_STALL - 1);

    state_t            state_q, state_d;
    logic [3:0]        rem_q, rem_d;
    logic [CWIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CWIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic              stall, flush;
    logic              lu_hit;

    // x0 is never a real destination, so a load targeting it cannot create a hazard
    assign lu_hit = hu_i_ce && hu_i_ex_ce && hu_i_ex_load
                 && (hu_i_ex_addr_rd != '0)
                 && ((hu_i_ex_addr_rd == hu_i_addr_rs1) || (hu_i_ex_addr_rd == hu_i_addr_rs2));

    always_comb begin
        stall   = 1'b0;
        flush   = 1'b0;
        state_d = state_q;
        rem_d   = rem_q;
        if (!hu_rst) begin
            if (hu_i_branch_taken) begin
                flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    rem_d   = FLUSH_REM;
                end else begin
                    state_d = ST_RUN;
                end
            end else if (state_q == ST_FLUSH) begin
                flush = 1'b1;
                rem_d = rem_q - 4'd1;
                if (rem_q == 4'd1) state_d = ST_RUN;
            end else if (state_q == ST_STALL) begin
                stall = 1'b1;
                rem_d = rem_q - 4'd1;
                if (rem_q == 4'd1) state_d = ST_RUN;
            end else if (hu_i_mc_busy) begin
                stall   = 1'b1;
                state_d = ST_MC_WAIT;
            end else if (lu_hit) begin
                // MC_WAIT with busy low lands here too, so a held hazard is caught at once
                stall = 1'b1;
                if (LU_STALL > 1) begin
                    state_d = ST_STALL;
                    rem_d   = LU_REM;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CWIDTH'(1);
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CWIDTH'(1);
    end

    always_ff @(posedge hu_clk) begin
        if (hu_rst) begin
            state_q     <= ST_RUN;
            rem_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hu_o_stall     = stall;
    assign hu_o_flush     = flush;
    assign hu_o_state     = state_q;
    assign hu_o_stall_cnt = stall_cnt_q;
    assign hu_o_flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control unit that drives the decode stage's `ds_i_stall` and `ds_i_flush` inputs.
- Detects load-use hazards between the instruction in decode and a load in execute.
- Holds the pipeline while a multi-cycle execute operation is busy.
- Sequences a multi-cycle flush after a taken branch.
- Keeps saturating stall and flush event counters for performance monitoring.

## Interface
Parameters:
- AWIDTH, 5, register address width
- CWIDTH, 16, width of each performance counter
- LU_STALL, 1, stall cycles per load-use hazard (legal 1..15)
- FLUSH_CYCLES, 2, flush cycles per taken branch (legal 1..15)

Ports:
- hu_clk  in  1  clock; all state updates on rising edge
- hu_rst  in  1  reset; synchronous, active-high
- hu_i_ce  in  1  decode stage holds a valid instruction
- hu_i_addr_rs1  in  AWIDTH  decode-stage rs1 address
- hu_i_addr_rs2  in  AWIDTH  decode-stage rs2 address
- hu_i_ex_ce  in  1  execute stage holds a valid instruction
- hu_i_ex_load  in  1  execute-stage instruction is a load
- hu_i_ex_addr_rd  in  AWIDTH  execute-stage rd address
- hu_i_branch_taken  in  1  execute stage resolved a taken branch/jump this cycle
- hu_i_mc_busy  in  1  multi-cycle execute operation in progress
- hu_o_stall  out  1  stall fetch/decode; connects to ds_i_stall
- hu_o_flush  out  1  flush fetch/decode; connects to ds_i_flush
- hu_o_state  out  2  current FSM state: RUN=0, STALL=1, FLUSH=2, MC_WAIT=3
- hu_o_stall_cnt  out  CWIDTH  cycles with hu_o_stall=1, saturating
- hu_o_flush_cnt  out  CWIDTH  cycles with hu_o_flush=1, saturating

## Operation
- **lu_hit** is asserted when all of the following hold:
  - hu_i_ce, hu_i_ex_ce and hu_i_ex_load are all 1;
  - hu_i_ex_addr_rd != 0;
  - hu_i_ex_addr_rd equals hu_i_addr_rs1 or hu_i_addr_rs2.
- A 4-bit internal counter **rem** holds the remaining cycles for STALL/FLUSH.
- hu_o_stall and hu_o_flush are combinational (Mealy) on state and inputs. They are never both 1.
- The per-cycle priority below applies in every state. The first matching rule wins.
  1. **hu_i_branch_taken=1:**
     - flush=1, stall=0.
     - If FLUSH_CYCLES>1: next FLUSH, rem←FLUSH_CYCLES-1. Otherwise next RUN.
     - This aborts any STALL/MC_WAIT. In FLUSH it restarts rem.
  2. **State FLUSH:**
     - flush=1, stall=0. hu_i_mc_busy and lu_hit are ignored.
     - rem←rem-1. When rem==1, next RUN.
  3. **State STALL:**
     - stall=1.
     - rem←rem-1. When rem==1, next RUN.
  4. **hu_i_mc_busy=1:**
     - stall=1, next MC_WAIT.
  5. **lu_hit=1:**
     - stall=1.
     - If LU_STALL>1: next STALL, rem←LU_STALL-1. Otherwise next RUN.
  6. **Otherwise:**
     - stall=0, flush=0, next RUN.
- In MC_WAIT with hu_i_mc_busy=0, the unit behaves exactly as RUN for that cycle. A pending lu_hit is detected in that same cycle.
- Counters:
  - Each counter increments by 1 on every clock edge where its output is 1.
  - Each counter holds at 2^CWIDTH-1 (no wrap).
  - Only reset clears the counters.

## Timing
- **Reset:**
  - While hu_rst=1: hu_o_stall=0, hu_o_flush=0, regardless of inputs.
  - On the first edge with hu_rst=1: state←RUN, rem←0, both counters←0, so hu_o_state=0.
  - Reset mid-STALL/FLUSH abandons the sequence. No residual stall or flush follows reset release.
- **Latency:**
  - Hazard, busy and branch responses appear in the same cycle as the cause (zero latency).
  - hu_o_state and the counters reflect that cycle after the next edge.
- **Load-use stall:** lasts exactly LU_STALL consecutive cycles, counting the detection cycle.
- **Flush:** lasts exactly FLUSH_CYCLES consecutive cycles after the last taken branch.
- **MC_WAIT stall:** lasts exactly as many cycles as hu_i_mc_busy is high.
- **rd=0:** a load with rd=x0 never stalls.
- **Validity:** hu_i_ce=0 or hu_i_ex_ce=0 suppresses lu_hit.
- **Simultaneous events:**
  - Branch with busy or lu_hit: flush only.
  - Busy with lu_hit: MC_WAIT, then lu_hit is re-evaluated when busy drops.

## Test plan
- **Reset:** hold hu_rst=1 with hu_i_mc_busy=1 and hu_i_branch_taken=1.
  - Expect stall=0, flush=0 throughout reset.
  - Expect state=0 and counters=0 after the first edge.
- **Load-use, LU_STALL=2:** ex_load=1, ex_rd=5, rs2=5, both ce=1.
  - Expect stall=1 for exactly 2 cycles; state sequence RUN→STALL→RUN; stall_cnt=2.
  - Repeat with ex_rd=0: expect no stall.
- **Branch flush, FLUSH_CYCLES=2:** pulse branch_taken for 1 cycle.
  - Expect flush=1 for 2 cycles, stall=0; flush_cnt=2.
  - A second pulse in the 2nd flush cycle extends the flush to 3 cycles total.
- **Multi-cycle wait:** mc_busy high for 4 cycles while lu_hit holds.
  - Expect stall=1 for 4 cycles in MC_WAIT.
  - Then stall continues for LU_STALL cycles via the lu_hit path.
  - Then RUN.
- **Priority:** branch_taken, mc_busy and lu_hit asserted together in STALL.
  - Expect flush=1, stall=0, next state FLUSH.
- **Saturation:** CWIDTH=4 with continuous mc_busy for 20 cycles.
  - Expect stall_cnt to reach 15 and hold.
  - Expect mid-run hu_rst to clear it to 0 and state to return to RUN.
